id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline stage of the rv32imc core; produces the ALU operands a/b and alu_op.
//  Captures decoded instructions under a valid/ready handshake.
//  Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and stalls decode on load-use.
//  Refreshes held operands while the stage is back-pressured, and counts stall cycles.
// PARAMETERS
//  XLEN        32  datapath width; operands, pc, imm, forward data
//  CNT_W       16  width of the saturating stall counter
// PORTS
//  clk            in   1     core clock, rising edge
//  rst_n          in   1     asynchronous active-low reset
//  flush          in   1     squash held instruction and incoming transfer
//  id_valid       in   1     decode presents an instruction
//  id_ready       out  1     stage accepts instruction this cycle
//  id_pc          in   XLEN  instruction pc
//  id_rs1_addr    in   5     source reg 1 index
//  id_rs2_addr    in   5     source reg 2 index
//  id_use_rs1     in   1     instruction reads rs1
//  id_use_rs2     in   1     instruction reads rs2
//  id_rs1_data    in   XLEN  regfile read data 1
//  id_rs2_data    in   XLEN  regfile read data 2
//  id_imm         in   XLEN  sign-extended immediate
//  id_a_sel_pc    in   1     ALU a = pc instead of rs1
//  id_b_sel_imm   in   1     ALU b = imm instead of rs2
//  id_alu_op      in   3     alu_op (rv32imc_types encoding)
//  id_rd_addr     in   5     destination reg index
//  id_rd_we       in   1     instruction writes rd
//  exm_rd_we      in   1     EX/MEM instruction writes rd
//  exm_rd_addr    in   5     EX/MEM destination index
//  exm_rd_rdy     in   1     EX/MEM result available (0 for in-flight load)
//  exm_rd_data    in   XLEN  EX/MEM result
//  wb_rd_we       in   1     MEM/WB instruction writes rd
//  wb_rd_addr     in   5     MEM/WB destination index
//  wb_rd_data     in   XLEN  MEM/WB result
//  ex_valid       out  1     operands for ALU are valid
//  ex_ready       in   1     EX consumes this cycle
//  ex_a           out  XLEN  ALU input a
//  ex_b           out  XLEN  ALU input b
//  ex_alu_op      out  3     ALU opcode
//  ex_store_data  out  XLEN  forwarded rs2 (store data)
//  ex_pc, ex_rd_addr, ex_rd_we  out  XLEN/5/1  registered sideband
//  stall_cnt      out  CNT_W load-use stall cycles, saturating
// BEHAVIOUR
//  Reset: ex_valid=0, all ex_* outputs=0, stall_cnt=0; id_ready then follows the hazard equation.
//  Forwarding per operand, rs==x0 never forwarded (value 0):
//   - Priority: EX/MEM (exm_rd_we & addr match & exm_rd_rdy) > MEM/WB > regfile.
//  hazard = id_valid & ((id_use_rs1 & rs1 hits EX/MEM with !exm_rd_rdy) | same for rs2), rs!=0.
//  id_ready = !hazard & (!ex_valid | ex_ready).
//  Transfer = id_valid & id_ready & !flush: next cycle ex_valid=1, forwarded operands and sideband latched.
//  Output muxes are combinational on held state:
//   - ex_a = sel_pc ? pc : rs1f; ex_b = sel_imm ? imm : rs2f; ex_store_data = rs2f.
//  Refresh: while ex_valid & !ex_ready, held rs1f/rs2f re-forwarded each cycle from EX/MEM/MEM/WB on match.
//   - Refresh never uses the regfile and never applies when held rs==0.
//  ex_valid & ex_ready & no new transfer -> ex_valid=0 next cycle; consume + transfer same cycle -> back-to-back.
//  flush: ex_valid=0 next cycle, takes priority over transfer and hold; outputs otherwise unchanged.
//  stall_cnt += 1 per cycle hazard=1, saturates at all-ones; flush does not clear it.
//  rst_n assert mid-operation: immediate (async) return to reset values; deassert synchronised externally.
//  Latency: 1 cycle id accept -> ex_valid.
// TESTING
//  rs1=x5 regfile 0x10, no forward, alu_add, b_sel_imm imm=4 -> next cycle ex_a=0x10, ex_b=4, ex_valid=1.
//  x5 in EX/MEM 0xAA rdy and MEM/WB 0xBB -> ex_a=0xAA; rs1=x0 with matches -> ex_a=0.
//  EX/MEM x7 with exm_rd_rdy=0, id uses x7 -> id_ready=0, stall_cnt +1/cycle; rdy=1 -> accepted with forwarded data.
//  Held instr, ex_ready=0 for 3 cycles, wb writes x9=0x55 to its rs2 -> ex_b/ex_store_data=0x55 before consume.
//  flush same cycle as id_valid=1 -> ex_valid=0 next cycle; back-to-back transfers, ex_ready=1 -> one per cycle.
//  rst_n low mid-stall -> ex_valid=0, stall_cnt=0 asynchronously; force stall_cnt to saturate -> holds at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register of the rv32imc core.
// Captures a decoded instruction, forwards its source operands from EX/MEM
// and MEM/WB, stalls decode on a load-use hazard, keeps held operands fresh
// while EX back-pressures, and counts load-use stall cycles.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Decode side: id_valid/id_ready; a transfer is suppressed by
// flush. EX side: ex_valid/ex_ready; ex_valid never depends on ex_ready, and
// while ex_valid is high and ex_ready is low the held instruction (and its
// sideband) stays in place, only its operand values may be refreshed.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_a_sel_pc,
  input  logic             id_b_sel_imm,
  input  logic [2:0]       id_alu_op,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_rd_we,
  input  logic             exm_rd_we,
  input  logic [4:0]       exm_rd_addr,
  input  logic             exm_rd_rdy,
  input  logic [XLEN-1:0]  exm_rd_data,
  input  logic             wb_rd_we,
  input  logic [4:0]       wb_rd_addr,
  input  logic [XLEN-1:0]  wb_rd_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_a,
  output logic [XLEN-1:0]  ex_b,
  output logic [2:0]       ex_alu_op,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [XLEN-1:0]  ex_pc,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_rd_we,
  output logic [CNT_W-1:0] stall_cnt
);

  // Held instruction state
  logic             r_ex_valid;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_imm;
  logic [4:0]       r_rs1_addr;
  logic [4:0]       r_rs2_addr;
  logic [XLEN-1:0]  r_rs1f;
  logic [XLEN-1:0]  r_rs2f;
  logic             r_a_sel_pc;
  logic             r_b_sel_imm;
  logic [2:0]       r_alu_op;
  logic [4:0]       r_rd_addr;
  logic             r_rd_we;
  logic [CNT_W-1:0] r_stall_cnt;

  // Decode-side forwarding and hazard detection
  logic            w_rs1_exm_hit;
  logic            w_rs2_exm_hit;
  logic            w_rs1_wb_hit;
  logic            w_rs2_wb_hit;
  logic [XLEN-1:0] w_rs1f;
  logic [XLEN-1:0] w_rs2f;
  logic            w_hazard;
  logic            w_id_ready;
  logic            w_transfer;

  // Held-operand refresh
  logic            w_h1_exm_hit;
  logic            w_h2_exm_hit;
  logic            w_h1_wb_hit;
  logic            w_h2_wb_hit;
  logic [XLEN-1:0] w_rs1_refresh;
  logic [XLEN-1:0] w_rs2_refresh;
  logic            w_hold;
  logic            w_cnt_max;

  // Address matches against the older in-flight writers; x0 never matches
  always_comb begin
    w_rs1_exm_hit = exm_rd_we && (exm_rd_addr == id_rs1_addr) && (id_rs1_addr != 5'd0);
    w_rs2_exm_hit = exm_rd_we && (exm_rd_addr == id_rs2_addr) && (id_rs2_addr != 5'd0);
    w_rs1_wb_hit  = wb_rd_we  && (wb_rd_addr  == id_rs1_addr) && (id_rs1_addr != 5'd0);
    w_rs2_wb_hit  = wb_rd_we  && (wb_rd_addr  == id_rs2_addr) && (id_rs2_addr != 5'd0);
  end

  // Forwarded rs1 for the incoming instruction: EX/MEM (if ready) > MEM/WB > regfile
  always_comb begin
    w_rs1f = id_rs1_data;
    if (id_rs1_addr == 5'd0) begin
      w_rs1f = '0;
    end else if (w_rs1_exm_hit && exm_rd_rdy) begin
      w_rs1f = exm_rd_data;
    end else if (w_rs1_wb_hit) begin
      w_rs1f = wb_rd_data;
    end
  end

  // Forwarded rs2 for the incoming instruction, same priority as rs1
  always_comb begin
    w_rs2f = id_rs2_data;
    if (id_rs2_addr == 5'd0) begin
      w_rs2f = '0;
    end else if (w_rs2_exm_hit && exm_rd_rdy) begin
      w_rs2f = exm_rd_data;
    end else if (w_rs2_wb_hit) begin
      w_rs2f = wb_rd_data;
    end
  end

  // Load-use hazard: a used source hits an EX/MEM result that is not yet available
  always_comb begin
    w_hazard   = id_valid &&
                 ((id_use_rs1 && w_rs1_exm_hit && !exm_rd_rdy) ||
                  (id_use_rs2 && w_rs2_exm_hit && !exm_rd_rdy));
    w_id_ready = !w_hazard && (!r_ex_valid || ex_ready);
    w_transfer = id_valid && w_id_ready && !flush;
    w_hold     = r_ex_valid && !ex_ready;
    w_cnt_max  = &r_stall_cnt;
  end

  // Refresh sources for the held operands; only bypass paths, never the regfile
  always_comb begin
    w_h1_exm_hit = exm_rd_we && exm_rd_rdy && (exm_rd_addr == r_rs1_addr) && (r_rs1_addr != 5'd0);
    w_h2_exm_hit = exm_rd_we && exm_rd_rdy && (exm_rd_addr == r_rs2_addr) && (r_rs2_addr != 5'd0);
    w_h1_wb_hit  = wb_rd_we && (wb_rd_addr == r_rs1_addr) && (r_rs1_addr != 5'd0);
    w_h2_wb_hit  = wb_rd_we && (wb_rd_addr == r_rs2_addr) && (r_rs2_addr != 5'd0);
    w_rs1_refresh = r_rs1f;
    if (w_h1_exm_hit) begin
      w_rs1_refresh = exm_rd_data;
    end else if (w_h1_wb_hit) begin
      w_rs1_refresh = wb_rd_data;
    end
    w_rs2_refresh = r_rs2f;
    if (w_h2_exm_hit) begin
      w_rs2_refresh = exm_rd_data;
    end else if (w_h2_wb_hit) begin
      w_rs2_refresh = wb_rd_data;
    end
  end

  // Valid bit: flush beats transfer, transfer beats hold, consume clears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_transfer) begin
      r_ex_valid <= 1'b1;
    end else if (r_ex_valid && ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

  // Payload: latch on transfer, refresh operands while held; flush leaves it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rs1f      <= '0;
      r_rs2f      <= '0;
      r_a_sel_pc  <= 1'b0;
      r_b_sel_imm <= 1'b0;
      r_alu_op    <= '0;
      r_rd_addr   <= '0;
      r_rd_we     <= 1'b0;
    end else if (flush) begin
      r_pc <= r_pc;
    end else if (w_transfer) begin
      r_pc        <= id_pc;
      r_imm       <= id_imm;
      r_rs1_addr  <= id_rs1_addr;
      r_rs2_addr  <= id_rs2_addr;
      r_rs1f      <= w_rs1f;
      r_rs2f      <= w_rs2f;
      r_a_sel_pc  <= id_a_sel_pc;
      r_b_sel_imm <= id_b_sel_imm;
      r_alu_op    <= id_alu_op;
      r_rd_addr   <= id_rd_addr;
      r_rd_we     <= id_rd_we;
    end else if (w_hold) begin
      r_rs1f <= w_rs1_refresh;
      r_rs2f <= w_rs2_refresh;
    end
  end

  // Saturating count of load-use stall cycles; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && !w_cnt_max) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Operand muxes act on held state so EX sees refreshed values immediately
  always_comb begin
    id_ready      = w_id_ready;
    ex_valid      = r_ex_valid;
    ex_a          = r_a_sel_pc  ? r_pc  : r_rs1f;
    ex_b          = r_b_sel_imm ? r_imm : r_rs2f;
    ex_store_data = r_rs2f;
    ex_alu_op     = r_alu_op;
    ex_pc         = r_pc;
    ex_rd_addr    = r_rd_addr;
    ex_rd_we      = r_rd_we;
    stall_cnt     = r_stall_cnt;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test of the ID->EX stage. Drivers push the
// expected EX-side payload into exp_q; a monitor pops it whenever EX
// consumes (ex_valid & ex_ready) and compares all fields.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam int EW    = 4*XLEN + 3 + 5 + 1;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic             flush, id_valid, id_ready;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic             id_use_rs1, id_use_rs2, id_a_sel_pc, id_b_sel_imm, id_rd_we;
  logic [2:0]       id_alu_op;
  logic             exm_rd_we, exm_rd_rdy;
  logic [4:0]       exm_rd_addr;
  logic [XLEN-1:0]  exm_rd_data;
  logic             wb_rd_we;
  logic [4:0]       wb_rd_addr;
  logic [XLEN-1:0]  wb_rd_data;
  logic             ex_valid, ex_ready, ex_rd_we;
  logic [XLEN-1:0]  ex_a, ex_b, ex_store_data, ex_pc;
  logic [2:0]       ex_alu_op;
  logic [4:0]       ex_rd_addr;
  logic [CNT_W-1:0] stall_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_a_sel_pc(id_a_sel_pc), .id_b_sel_imm(id_b_sel_imm), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .exm_rd_we(exm_rd_we), .exm_rd_addr(exm_rd_addr), .exm_rd_rdy(exm_rd_rdy),
    .exm_rd_data(exm_rd_data),
    .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .stall_cnt(stall_cnt)
  );

  // Scoreboard state
  int n_pass  = 0;
  int n_total = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare every consumed EX payload against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {31'd0, ex_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ex_a",          ex_a,                  mon_e[136:105]);
        check("ex_b",          ex_b,                  mon_e[104:73]);
        check("ex_store_data", ex_store_data,         mon_e[72:41]);
        check("ex_pc",         ex_pc,                 mon_e[40:9]);
        check("ex_alu_op",     {29'd0, ex_alu_op},    {29'd0, mon_e[8:6]});
        check("ex_rd_addr",    {27'd0, ex_rd_addr},   {27'd0, mon_e[5:1]});
        check("ex_rd_we",      {31'd0, ex_rd_we},     {31'd0, mon_e[0]});
      end
    end
  end

  // Driver tasks
  task automatic drive_id(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                          input logic u1, input logic u2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic spc, input logic simm, input logic [2:0] op,
                          input logic [4:0] rd, input logic we);
    id_pc = pc; id_rs1_addr = r1; id_rs2_addr = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_a_sel_pc = spc;
    id_b_sel_imm = simm; id_alu_op = op; id_rd_addr = rd; id_rd_we = we;
    id_valid = 1'b1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st);
    exp_q.push_back({a, b, st, id_pc, id_alu_op, id_rd_addr, id_rd_we});
  endtask

  // Wait (bounded) until the presented instruction is accepted; returns extra cycles waited
  task automatic wait_accept(output int waited);
    bit done;
    done = 1'b0;
    waited = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (id_ready && !flush) done = 1'b1;
      else waited++;
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", {31'd0, id_ready}, 32'd1);
  endtask

  int w;

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_a_sel_pc = 1'b0; id_b_sel_imm = 1'b0;
    id_alu_op = '0; id_rd_addr = '0; id_rd_we = 1'b0;
    exm_rd_we = 1'b0; exm_rd_addr = '0; exm_rd_rdy = 1'b1; exm_rd_data = '0;
    wb_rd_we = 1'b0; wb_rd_addr = '0; wb_rd_data = '0;

    // Reset values
    #3;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_a", ex_a, 32'd0);
    check("rst_ex_b", ex_b, 32'd0);
    check("rst_ex_store", ex_store_data, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_id_ready", {31'd0, id_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Plain regfile operand with immediate b, 1-cycle latency
    drive_id(32'h100, 5'd5, 5'd0, 1, 0, 32'h10, 32'h999, 32'd4, 0, 1, 3'd0, 5'd1, 1);
    push_exp(32'h10, 32'd4, 32'd0);
    wait_accept(w);
    check("t1_latency_valid", {31'd0, ex_valid}, 32'd1);

    // EX/MEM wins over MEM/WB; issued back to back
    exm_rd_we = 1; exm_rd_addr = 5'd5; exm_rd_rdy = 1; exm_rd_data = 32'hAA;
    wb_rd_we = 1; wb_rd_addr = 5'd5; wb_rd_data = 32'hBB;
    drive_id(32'h104, 5'd5, 5'd5, 1, 1, 32'h10, 32'h20, 32'd0, 0, 0, 3'd1, 5'd2, 1);
    push_exp(32'hAA, 32'hAA, 32'hAA);
    wait_accept(w);
    check("b2b_t2_wait", w, 32'd0);

    // x0 sources read as zero even with matching writers
    exm_rd_addr = 5'd0; wb_rd_addr = 5'd0;
    drive_id(32'h108, 5'd0, 5'd0, 1, 1, 32'h10, 32'h20, 32'd0, 0, 0, 3'd2, 5'd3, 1);
    push_exp(32'd0, 32'd0, 32'd0);
    wait_accept(w);
    check("b2b_t3_wait", w, 32'd0);

    // MEM/WB only; immediate on b, store data still forwarded
    exm_rd_we = 0; wb_rd_addr = 5'd5;
    drive_id(32'h10C, 5'd5, 5'd5, 1, 1, 32'h10, 32'h20, 32'h7FC, 0, 1, 3'd4, 5'd4, 1);
    push_exp(32'hBB, 32'h7FC, 32'hBB);
    wait_accept(w);
    check("b2b_t4_wait", w, 32'd0);

    // pc on a, regfile rs2 on b
    drive_id(32'h200, 5'd5, 5'd6, 1, 1, 32'h10, 32'h20, 32'd0, 1, 0, 3'd3, 5'd5, 0);
    push_exp(32'h200, 32'h20, 32'h20);
    wait_accept(w);
    check("b2b_t5_wait", w, 32'd0);
    check("b2b_valid", {31'd0, ex_valid}, 32'd1);
    id_valid = 0; wb_rd_we = 0;

    // Load-use stall on x7, flush during the stall must not clear the counter
    exm_rd_we = 1; exm_rd_addr = 5'd7; exm_rd_rdy = 0; exm_rd_data = 32'h77;
    drive_id(32'h300, 5'd7, 5'd0, 1, 0, 32'h70, 32'd0, 32'd0, 0, 0, 3'd5, 5'd8, 1);
    for (int i = 0; i < 3; i++) begin
      #1 check("hazard_id_ready", {31'd0, id_ready}, 32'd0);
      flush = (i == 1);
      @(posedge clk); #1 flush = 0;
    end
    check("stall_cnt_3", {16'd0, stall_cnt}, 32'd3);
    exm_rd_rdy = 1; exm_rd_data = 32'h7A;
    push_exp(32'h7A, 32'd0, 32'd0);
    wait_accept(w);
    check("hazard_release_wait", w, 32'd0);
    check("stall_cnt_hold", {16'd0, stall_cnt}, 32'd3);
    id_valid = 0; exm_rd_we = 0;
    @(posedge clk); #1;

    // Held instruction refreshed from MEM/WB, never from the regfile
    ex_ready = 0;
    drive_id(32'h400, 5'd3, 5'd9, 1, 1, 32'h33, 32'h11, 32'd0, 0, 0, 3'd6, 5'd10, 1);
    push_exp(32'h33, 32'h55, 32'h55);
    wait_accept(w);
    id_valid = 0;
    check("held_id_ready", {31'd0, id_ready}, 32'd0);
    @(posedge clk); #1;
    wb_rd_we = 1; wb_rd_addr = 5'd9; wb_rd_data = 32'h55;
    @(posedge clk); #1;
    wb_rd_we = 0; id_rs2_addr = 5'd9; id_rs2_data = 32'h99;
    check("refresh_b", ex_b, 32'h55);
    @(posedge clk); #1;
    ex_ready = 1;
    @(posedge clk); #1;
    check("consumed_valid", {31'd0, ex_valid}, 32'd0);

    // Flush together with an incoming instruction
    flush = 1;
    drive_id(32'h500, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 32'd0, 0, 0, 3'd1, 5'd11, 1);
    @(posedge clk); #1 flush = 0; id_valid = 0;
    check("flush_new_valid", {31'd0, ex_valid}, 32'd0);

    // Flush of a held instruction leaves the payload in place
    ex_ready = 0;
    drive_id(32'h600, 5'd1, 5'd2, 1, 1, 32'h1, 32'h2, 32'd0, 0, 0, 3'd2, 5'd12, 1);
    wait_accept(w);
    id_valid = 0;
    check("held_600_valid", {31'd0, ex_valid}, 32'd1);
    flush = 1;
    @(posedge clk); #1 flush = 0;
    check("flush_held_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_held_pc", ex_pc, 32'h600);

    // Asynchronous reset in the middle of a stall with a held instruction
    drive_id(32'h700, 5'd1, 5'd0, 1, 0, 32'h1, 32'h0, 32'd0, 0, 0, 3'd3, 5'd13, 1);
    wait_accept(w);
    exm_rd_we = 1; exm_rd_addr = 5'd7; exm_rd_rdy = 0;
    drive_id(32'h704, 5'd7, 5'd0, 1, 0, 32'h1, 32'h0, 32'd0, 0, 0, 3'd3, 5'd14, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
    #2 rst_n = 0;
    #1;
    check("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    check("async_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    check("async_rst_ex_a", ex_a, 32'd0);
    check("async_rst_ex_pc", ex_pc, 32'd0);
    check("async_rst_id_ready", {31'd0, id_ready}, 32'd0);
    @(posedge clk); #1 rst_n = 1;

    // Stall held long enough to saturate the counter
    repeat (65534) @(posedge clk);
    #1 check("stall_cnt_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
    repeat (4) @(posedge clk);
    #1 check("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);

    id_valid = 0; exm_rd_we = 0; ex_ready = 1;
    repeat (2) @(posedge clk);
    #1 check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
